// File: rtl/slime_pkg.sv
// rtl/slime_pkg.sv - shared state/select types and screen constants for the slime motion controller
package slime_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        LAND
    } slime_state_t;

    typedef enum logic [1:0] {
        JUMP_NONE,
        JUMP_LO,
        JUMP_MED,
        JUMP_HI
    } jump_sel_t;

    localparam int X_MIN    = 0;
    localparam int X_MAX    = 639;
    localparam int Y_GROUND = 479;

    // Fixed priority: the strongest requested jump wins.
    function automatic jump_sel_t jump_select(input logic hi, input logic med, input logic lo);
        if (hi)       return JUMP_HI;
        else if (med) return JUMP_MED;
        else if (lo)  return JUMP_LO;
        else          return JUMP_NONE;
    endfunction

endpackage

// File: rtl/slime_x_mover.sv
// rtl/slime_x_mover.sv - registered horizontal position with per-frame step and wall clamp
module slime_x_mover
    import slime_pkg::*;
#(
    parameter int X_CENTER = 400,
    parameter int X_STEP   = 5,
    parameter int SIZE     = 50
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       key_left,
    input  logic       key_right,
    output logic [9:0] SlimeX
);

    localparam logic signed [10:0] C_X_LO = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] C_X_HI = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] C_STEP = 11'(X_STEP);

    logic        [9:0]  r_x;
    logic signed [10:0] w_x_sum;
    logic        [9:0]  w_x_nxt;

    always_comb begin
        w_x_sum = $signed({1'b0, r_x});
        if (key_left ^ key_right) begin
            w_x_sum = key_right ? w_x_sum + C_STEP : w_x_sum - C_STEP;
        end
        // Clamp in signed 11-bit so a step past either wall can never wrap.
        if (w_x_sum < C_X_LO)      w_x_nxt = C_X_LO[9:0];
        else if (w_x_sum > C_X_HI) w_x_nxt = C_X_HI[9:0];
        else                       w_x_nxt = w_x_sum[9:0];
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) r_x <= 10'(X_CENTER);
        else       r_x <= w_x_nxt;
    end

    assign SlimeX = r_x;

endmodule

// File: rtl/slime_motion_ctrl.sv
// rtl/slime_motion_ctrl.sv - per-frame slime jump FSM, gravity and floor/ceiling clamp
module slime_motion_ctrl
    import slime_pkg::*;
#(
    parameter int X_CENTER    = 400,
    parameter int SIZE        = 50,
    parameter int X_STEP      = 5,
    parameter int GRAVITY     = 1,
    parameter int V_HIGH      = 15,
    parameter int V_MED       = 12,
    parameter int V_LOW       = 10,
    parameter int V_TERM      = 8,
    parameter int LAND_FRAMES = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       key_hi,
    input  logic       key_med,
    input  logic       key_lo,
    input  logic       key_left,
    input  logic       key_right,
    output logic [9:0] SlimeX,
    output logic [9:0] SlimeY,
    output logic [9:0] SlimeS,
    output logic       airborne,
    output logic       jump_ack
);

    localparam logic signed [10:0] C_GROUND = 11'(Y_GROUND);
    localparam logic signed [10:0] C_CEIL   = 11'(SIZE);
    localparam logic signed [10:0] C_GRAV   = 11'(GRAVITY);
    localparam logic signed [10:0] C_VTERM  = 11'(V_TERM);
    localparam logic [7:0] LAND_INIT = (LAND_FRAMES == 0) ? 8'd0 : 8'(LAND_FRAMES - 1);

    slime_state_t       r_state, w_state_nxt;
    logic        [9:0]  r_y, w_y_nxt;
    logic signed [10:0] r_vy, w_vy_nxt;
    logic        [7:0]  r_land_cnt, w_land_cnt_nxt;
    logic               r_jump_ack, r_airborne;
    logic               w_accept;
    jump_sel_t          w_sel;
    logic signed [10:0] w_launch;
    logic signed [10:0] w_y_sum;
    logic signed [10:0] w_vy_inc;

    slime_x_mover #(
        .X_CENTER (X_CENTER),
        .X_STEP   (X_STEP),
        .SIZE     (SIZE)
    ) u_x_mover (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .key_left  (key_left),
        .key_right (key_right),
        .SlimeX    (SlimeX)
    );

    assign w_y_sum  = $signed({1'b0, r_y}) + r_vy;
    assign w_vy_inc = r_vy + C_GRAV;

    always_comb begin
        w_sel = jump_select(key_hi, key_med, key_lo);
        case (w_sel)
            JUMP_HI:  w_launch = 11'(V_HIGH);
            JUMP_MED: w_launch = 11'(V_MED);
            JUMP_LO:  w_launch = 11'(V_LOW);
            default:  w_launch = '0;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_y_nxt        = r_y;
        w_vy_nxt       = r_vy;
        w_land_cnt_nxt = r_land_cnt;
        w_accept       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel != JUMP_NONE) begin
                    w_accept    = 1'b1;
                    w_vy_nxt    = -w_launch;
                    w_state_nxt = RISE;
                end
            end
            RISE: begin
                // Ceiling hit wins over the normal apex transition.
                if (w_y_sum < C_CEIL) begin
                    w_y_nxt     = C_CEIL[9:0];
                    w_vy_nxt    = '0;
                    w_state_nxt = FALL;
                end else begin
                    w_y_nxt  = w_y_sum[9:0];
                    w_vy_nxt = w_vy_inc;
                    if (w_vy_inc >= 0) w_state_nxt = FALL;
                end
            end
            FALL: begin
                if (w_y_sum >= C_GROUND) begin
                    w_y_nxt        = C_GROUND[9:0];
                    w_vy_nxt       = '0;
                    w_land_cnt_nxt = LAND_INIT;
                    w_state_nxt    = LAND;
                end else begin
                    w_y_nxt  = w_y_sum[9:0];
                    w_vy_nxt = (w_vy_inc > C_VTERM) ? C_VTERM : w_vy_inc;
                end
            end
            LAND: begin
                if (r_land_cnt == 8'd0) w_state_nxt = IDLE;
                else                    w_land_cnt_nxt = r_land_cnt - 8'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_y        <= 10'(Y_GROUND);
            r_vy       <= '0;
            r_land_cnt <= '0;
            r_jump_ack <= 1'b0;
            r_airborne <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_y        <= w_y_nxt;
            r_vy       <= w_vy_nxt;
            r_land_cnt <= w_land_cnt_nxt;
            r_jump_ack <= w_accept;
            r_airborne <= (w_state_nxt == RISE) || (w_state_nxt == FALL);
        end
    end

    assign SlimeY   = r_y;
    assign SlimeS   = 10'(SIZE);
    assign airborne = r_airborne;
    assign jump_ack = r_jump_ack;

endmodule

// File: tb/tb_slime_motion_ctrl.sv
// tb/tb_slime_motion_ctrl.sv - directed self-checking bench for slime_motion_ctrl
module tb_slime_motion_ctrl;
    import slime_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       key_hi, key_med, key_lo, key_left, key_right;
    logic [9:0] SlimeX, SlimeY, SlimeS;
    logic       airborne, jump_ack;

    logic       k2_hi, k2_med, k2_lo, k2_left, k2_right;
    logic [9:0] x2, y2, s2;
    logic       air2, ack2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 frame_clk = ~frame_clk;

    slime_motion_ctrl dut (
        .frame_clk (frame_clk), .Reset (Reset),
        .key_hi (key_hi), .key_med (key_med), .key_lo (key_lo),
        .key_left (key_left), .key_right (key_right),
        .SlimeX (SlimeX), .SlimeY (SlimeY), .SlimeS (SlimeS),
        .airborne (airborne), .jump_ack (jump_ack)
    );

    slime_motion_ctrl #(.V_HIGH(30)) dut2 (
        .frame_clk (frame_clk), .Reset (Reset),
        .key_hi (k2_hi), .key_med (k2_med), .key_lo (k2_lo),
        .key_left (k2_left), .key_right (k2_right),
        .SlimeX (x2), .SlimeY (y2), .SlimeS (s2),
        .airborne (air2), .jump_ack (ack2)
    );

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dut.r_state != IDLE && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        Reset = 1'b1;
        {key_hi, key_med, key_lo, key_left, key_right} = '0;
        {k2_hi, k2_med, k2_lo, k2_left, k2_right} = '0;
        tick(); tick();
        chk("reset_x", 32'(SlimeX), 32'd400);
        chk("reset_y", 32'(SlimeY), 32'd479);
        chk("reset_s", 32'(SlimeS), 32'd50);
        chk("reset_air", 32'(airborne), 32'd0);
        chk("reset_ack", 32'(jump_ack), 32'd0);
        chk("reset_state", 32'(dut.r_state), 32'(IDLE));
        chk("reset_y2", 32'(y2), 32'd479);
        Reset = 1'b0;

        // Single high jump: rise to apex, saturating fall, land, LAND frames
        key_hi = 1'b1; tick(); key_hi = 1'b0;
        chk("t1_ack", 32'(jump_ack), 32'd1);
        chk("t1_y_accept", 32'(SlimeY), 32'd479);
        chk("t1_air", 32'(airborne), 32'd1);
        tick();
        chk("t1_y1", 32'(SlimeY), 32'd464);
        chk("t1_ack_pulse", 32'(jump_ack), 32'd0);
        tick();
        chk("t1_y2", 32'(SlimeY), 32'd450);
        key_lo = 1'b1;
        repeat (13) begin tick(); chk("t1_rise_noack", 32'(jump_ack), 32'd0); end
        key_lo = 1'b0;
        chk("t1_apex", 32'(SlimeY), 32'd359);
        chk("t1_apex_state", 32'(dut.r_state), 32'(FALL));
        repeat (8) tick();
        chk("t1_fall8", 32'(SlimeY), 32'd387);
        tick();
        chk("t1_fall9", 32'(SlimeY), 32'd395);
        chk("t1_vterm", 32'(dut.r_vy), 32'd8);
        tick();
        chk("t1_fall10", 32'(SlimeY), 32'd403);
        key_med = 1'b1;
        repeat (9) begin tick(); chk("t1_fall_noack", 32'(jump_ack), 32'd0); end
        chk("t1_fall19", 32'(SlimeY), 32'd475);
        tick();
        chk("t1_land_y", 32'(SlimeY), 32'd479);
        chk("t1_land_air", 32'(airborne), 32'd0);
        repeat (3) begin
            tick();
            chk("t1_land_state", 32'(dut.r_state), 32'(LAND));
            chk("t1_land_noack", 32'(jump_ack), 32'd0);
        end
        key_med = 1'b0;
        tick();
        chk("t1_idle", 32'(dut.r_state), 32'(IDLE));

        // Priority among simultaneous keys
        {key_hi, key_med, key_lo} = 3'b111; tick(); {key_hi, key_med, key_lo} = 3'b000;
        chk("t2_ack_all", 32'(jump_ack), 32'd1);
        repeat (15) tick();
        chk("t2_apex_hi", 32'(SlimeY), 32'd359);
        wait_idle("t2_wait_idle_a");
        {key_med, key_lo} = 2'b11; tick(); {key_med, key_lo} = 2'b00;
        chk("t2_ack_med", 32'(jump_ack), 32'd1);
        repeat (12) tick();
        chk("t2_apex_med", 32'(SlimeY), 32'd401);
        wait_idle("t2_wait_idle_b");

        // Held key: back-to-back jumps with 4 LAND frames between
        key_lo = 1'b1; tick();
        chk("t3_ack_first", 32'(jump_ack), 32'd1);
        repeat (2) begin
            n = 0;
            while (airborne !== 1'b0 && n < 100) begin tick(); n++; end
            chk("t3_landed", 32'(n < 100), 32'd1);
            n = 0;
            do begin tick(); n++; end while (jump_ack !== 1'b1 && n < 20);
            chk("t3_gap", 32'(n), 32'd5);
        end
        key_lo = 1'b0;
        wait_idle("t3_wait_idle");

        // Horizontal stepping and wall clamps
        chk("t4_x0", 32'(SlimeX), 32'd400);
        key_right = 1'b1; tick();
        chk("t4_x_r1", 32'(SlimeX), 32'd405);
        repeat (36) tick();
        chk("t4_x_585", 32'(SlimeX), 32'd585);
        tick(); chk("t4_x_clamp_r", 32'(SlimeX), 32'd589);
        tick(); chk("t4_x_hold_r", 32'(SlimeX), 32'd589);
        key_right = 1'b0; key_left = 1'b1;
        repeat (107) tick();
        chk("t4_x_54", 32'(SlimeX), 32'd54);
        tick(); chk("t4_x_clamp_l", 32'(SlimeX), 32'd50);
        tick(); chk("t4_x_hold_l", 32'(SlimeX), 32'd50);
        key_right = 1'b1; repeat (3) tick();
        chk("t4_x_both", 32'(SlimeX), 32'd50);
        key_left = 1'b0; tick();
        chk("t4_x_off_wall", 32'(SlimeX), 32'd55);
        key_left = 1'b1; repeat (2) tick();
        chk("t4_x_both2", 32'(SlimeX), 32'd55);
        {key_left, key_right} = 2'b00;

        // Ceiling clamp with a strong launch
        k2_hi = 1'b1; tick(); k2_hi = 1'b0;
        chk("t5_ack", 32'(ack2), 32'd1);
        repeat (21) tick();
        chk("t5_y21", 32'(y2), 32'd59);
        tick(); chk("t5_y22", 32'(y2), 32'd50);
        tick(); chk("t5_y_ceil", 32'(y2), 32'd50);
        chk("t5_ceil_state", 32'(dut2.r_state), 32'(FALL));
        chk("t5_ceil_vy", 32'(dut2.r_vy), 32'd0);
        tick(); chk("t5_f1", 32'(y2), 32'd50);
        tick(); chk("t5_f2", 32'(y2), 32'd51);
        tick(); chk("t5_f3", 32'(y2), 32'd53);

        // Reset mid-FALL with key_right held
        key_hi = 1'b1; key_right = 1'b1; tick(); key_hi = 1'b0;
        repeat (18) tick();
        chk("t6_pre_state", 32'(dut.r_state), 32'(FALL));
        chk("t6_pre_y", 32'(SlimeY), 32'd362);
        Reset = 1'b1; tick();
        chk("t6_x", 32'(SlimeX), 32'd400);
        chk("t6_y", 32'(SlimeY), 32'd479);
        chk("t6_air", 32'(airborne), 32'd0);
        chk("t6_ack", 32'(jump_ack), 32'd0);
        chk("t6_state", 32'(dut.r_state), 32'(IDLE));
        Reset = 1'b0; key_right = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
